sha256_padder: RTL



---
 rtl/sha256_padder_pkg.sv | 21 ++
 rtl/sha256_padder_if.sv | 27 ++
 rtl/sha256_padder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sha256_padder_pkg.sv
// Shared constants, FSM state type and padding helper for the SHA-256 byte padder.
package sha256_padder_pkg;

  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned LEN_W   = 64;

  // StExtra is the one-cycle bubble in which the extra padding block is built.
  typedef enum logic [1:0] {
    StFill,
    StEmit,
    StExtra
  } state_e;

  // Block-wide vector with 0x80 in the byte right after byte idx; all zero when idx is 63.
  function automatic logic [BLOCK_W-1:0] pad_tail(input logic [5:0] idx);
    logic [BLOCK_W-1:0] marker;
    marker = {8'h80, {(BLOCK_W - 8){1'b0}}};
    return marker >> (8 * (int'(idx) + 1));
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Byte input stream and 512-bit block output stream of the padder.
interface sha256_padder_if;
  import sha256_padder_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               blk_first;
  logic               blk_last;

  // Environment side: byte source and block consumer.
  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  // Padder side.
  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );

endinterface

// File: rtl/sha256_padder.sv
// Streams message bytes into 512-bit blocks with SHA-256 padding and length trailer.
module sha256_padder
  import sha256_padder_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input logic             clk,
  input logic             rst,
  sha256_padder_if.slave  bus
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;
  logic               mark_q, mark_d;
  logic [LEN_W-1:0]   len_inc, len_cur;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Bit length is the byte count shifted by 3, zero-extended to the 64-bit field.
  assign len_inc = LEN_W'({cnt_inc, 3'b000});
  assign len_cur = LEN_W'({cnt_q, 3'b000});

  // Moore outputs; in_ready is also held low while reset is asserted.
  always_comb begin
    bus.in_ready  = (state_q == StFill) && !rst;
    bus.blk_valid = (state_q == StEmit);
    bus.blk_data  = buf_q;
    bus.blk_first = (state_q == StEmit) && first_q;
    bus.blk_last  = (state_q == StEmit) && last_q;
  end

  // Next-state logic: buffer fill, padding insertion and block hand-off.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    pend_d  = pend_q;
    mark_d  = mark_q;
    unique case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          buf_d[8 * (63 - int'(idx_q)) +: 8] = bus.in_data;
          idx_d = idx_q + 6'd1;
          cnt_d = cnt_inc;
          if (bus.in_last) begin
            // Marker byte goes after the last data byte when there is room in this block.
            buf_d   = buf_d | pad_tail(idx_q);
            state_d = StEmit;
            if (idx_q <= 6'd54) begin
              buf_d[LEN_W-1:0] = len_inc;
              last_d = 1'b1;
            end else begin
              // Length does not fit: an extra block follows; mark says it carries the 0x80.
              last_d = 1'b0;
              pend_d = 1'b1;
              mark_d = (idx_q == 6'd63);
            end
          end else if (idx_q == 6'd63) begin
            last_d  = 1'b0;
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (bus.blk_ready) begin
          if (pend_q) begin
            pend_d  = 1'b0;
            first_d = 1'b0;
            state_d = StExtra;
          end else if (last_q) begin
            buf_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            first_d = 1'b1;
            last_d  = 1'b0;
            state_d = StFill;
          end else begin
            buf_d   = '0;
            idx_d   = '0;
            first_d = 1'b0;
            state_d = StFill;
          end
        end
      end
      StExtra: begin
        buf_d            = '0;
        buf_d[BLOCK_W-1] = mark_q;
        buf_d[LEN_W-1:0] = len_cur;
        idx_d            = '0;
        last_d           = 1'b1;
        state_d          = StEmit;
      end
      default: state_d = StFill;
    endcase
  end

  // State registers; reset discards any partially buffered message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      mark_q  <= mark_d;
    end
  end

endmodule
